// File: rtl/div_unit_pkg.sv
// Shared types and widths for the iterative divider (div_unit).
package div_unit_pkg;

   localparam int unsigned DataW     = 32;
   localparam int unsigned ResultW   = 2 * DataW;
   localparam int unsigned CntW      = 5;
   localparam int unsigned StallBusW = 6;

   // Divider control states (2-bit encoding)
   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   // Two's-complement negate when neg is set, pass-through otherwise
   function automatic logic [DataW-1:0] neg_if(input logic neg, input logic [DataW-1:0] x);
      return neg ? (~x + DataW'(1)) : x;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: 33-bit trial subtract of the divisor
// from the shifted partial remainder, yielding next remainder and quotient bit.
module div_step
   import div_unit_pkg::*;
(
   input  logic [DataW-1:0] rem,
   input  logic             msb,
   input  logic [DataW-1:0] divisor,
   output logic [DataW-1:0] rem_next,
   output logic             q_bit
);

   logic             hi;
   logic [DataW-1:0] low;
   logic             borrow;
   logic [DataW-1:0] diff;

   // Bit shifted out of the remainder means the shifted value exceeds any divisor
   always_comb begin
      hi            = rem[DataW-1];
      low           = {rem[DataW-2:0], msb};
      {borrow, diff} = {1'b0, low} - {1'b0, divisor};
      q_bit         = hi | ~borrow;
      rem_next      = q_bit ? diff : low;
   end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider, 32 restoring steps per result.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor short-cuts through
// BY_ZERO and returns {dividend, 32'hFFFF_FFFF} two cycles after acceptance.
module div_unit
   import div_unit_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [DataW-1:0]   opdata1_i,
   input  logic [DataW-1:0]   opdata2_i,
   input  logic               annul_i,
   output logic [ResultW-1:0] result_o,
   output logic               ready_o,
   output logic               stallreq_for_ex
);

   div_state_e       state;
   logic [CntW-1:0]  cnt;
   logic [DataW-1:0] rem_q;
   logic [DataW-1:0] quo_q;
   logic [DataW-1:0] dvs_q;
   logic             neg_quo;
   logic             neg_rem;

   logic             a_neg;
   logic             b_neg;
   logic [DataW-1:0] rem_next;
   logic             q_bit;
   logic [DataW-1:0] quo_next;

   div_step u_step (
      .rem      (rem_q),
      .msb      (quo_q[DataW-1]),
      .divisor  (dvs_q),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   // Operand signs at acceptance and the quotient after this step
   always_comb begin
      a_neg    = signed_i & opdata1_i[DataW-1];
      b_neg    = signed_i & opdata2_i[DataW-1];
      quo_next = {quo_q[DataW-2:0], q_bit};
   end

   // EX is frozen while a request is outstanding and no result is presented
   assign stallreq_for_ex = start_i & ~annul_i & (state != DivEnd);

   // Divider control, datapath and registered result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= DivFree;
         cnt      <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            DivFree: begin
               result_o <= '0;
               ready_o  <= 1'b0;
               if (start_i && !annul_i) begin
                  cnt     <= '0;
                  rem_q   <= '0;
                  quo_q   <= neg_if(a_neg, opdata1_i);
                  dvs_q   <= neg_if(b_neg, opdata2_i);
                  neg_quo <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
`ifdef DIV_ZERO_FAST_EN
                  if (opdata2_i == '0) begin
                     quo_q <= opdata1_i;
                     state <= DivByZero;
                  end else begin
                     state <= DivOn;
                  end
`else
                  state   <= DivOn;
`endif
               end
            end
`ifdef DIV_ZERO_FAST_EN
            DivByZero: begin
               if (annul_i) begin
                  state    <= DivFree;
                  cnt      <= '0;
                  result_o <= '0;
                  ready_o  <= 1'b0;
               end else begin
                  state    <= DivEnd;
                  result_o <= {quo_q, {DataW{1'b1}}};
                  ready_o  <= 1'b1;
               end
            end
`endif
            DivOn: begin
               if (annul_i) begin
                  state    <= DivFree;
                  cnt      <= '0;
                  result_o <= '0;
                  ready_o  <= 1'b0;
               end else begin
                  rem_q <= rem_next;
                  quo_q <= quo_next;
                  cnt   <= cnt + CntW'(1);
                  if (cnt == CntW'(DataW - 1)) begin
                     state    <= DivEnd;
                     result_o <= {neg_if(neg_rem, rem_next), neg_if(neg_quo, quo_next)};
                     ready_o  <= 1'b1;
                  end
               end
            end
            DivEnd: begin
               state    <= DivFree;
               cnt      <= '0;
               result_o <= '0;
               ready_o  <= 1'b0;
            end
            default: begin
               state    <= DivFree;
               cnt      <= '0;
               result_o <= '0;
               ready_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start_i  input  1  EX-stage request to divide; held high by EX until ready_o seen.
REQ-004 signed_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-005 opdata1_i  input  32  dividend; sampled on acceptance.
REQ-006 opdata2_i  input  32  divisor; sampled on acceptance.
REQ-007 annul_i  input  1  abort current division; no result produced.
REQ-008 result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-009 ready_o  output  1  result_o valid this cycle.
REQ-010 stallreq_for_ex  output  1  request to CTRL to freeze PC, IF, ID and EX.

Function
REQ-011 The block SHALL implement states FREE, BY_ZERO, ON and END.
REQ-012 In FREE, start_i=1 and annul_i=0 SHALL accept the request: latch the operands and signed_i, clear the iteration counter, go to ON (or to BY_ZERO per REQ-021).
REQ-013 On acceptance with signed_i=1, negative operands SHALL be converted to their two's-complement magnitudes before iterating.
REQ-014 ON SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles (counter 0..31), then go to END.
REQ-015 On entry to END, the block SHALL apply the sign correction when signed: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
REQ-016 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0.
REQ-017 END SHALL last exactly one cycle with ready_o=1 and result_o valid, then go to FREE unconditionally.
REQ-018 stallreq_for_ex SHALL equal start_i AND (state != END), computed combinationally. It SHALL be 0 when annul_i=1.
REQ-019 Latency from acceptance cycle t: ready_o=1 in cycle t+33.
- A back-to-back start_i in the cycle after END SHALL be accepted normally.
REQ-020 annul_i=1 in ON, BY_ZERO or END SHALL force FREE next cycle; ready_o=0 from that cycle.
- Operand or start_i changes during ON SHALL be ignored.
- result_o SHALL be 0 whenever ready_o=0.

Reset
REQ-022 rst=1 SHALL asynchronously force FREE, counter 0, result_o=0, ready_o=0, even mid-division; the in-flight result is discarded.
REQ-023 After rst deasserts, the first rising edge with start_i=1 SHALL be accepted.

Configuration
REQ-021 Macro DIV_ZERO_FAST_EN:
- Defined: a zero divisor at acceptance SHALL go FREE->BY_ZERO->END, with ready_o in cycle t+2 and result_o={opdata1 latched, 32'hFFFF_FFFF}, signed or unsigned.
- Undefined: a zero divisor SHALL take the normal 33-cycle path, and the result SHALL be the natural algorithm output. For unsigned that output is quotient 0xFFFFFFFF with remainder equal to the dividend. No BY_ZERO state is synthesised.

Structure
REQ-024 State encodings (2-bit), DivFree/DivByZero/DivOn/DivEnd, and the 64-bit result bus width SHALL live in lib/defines.vh alongside StallBus.
REQ-025 One combinational sub-module div_step SHALL be used: a 33-bit trial subtract giving the next partial remainder and quotient bit.
REQ-026 The stall is not self-cancelling: div_unit has no stall input, and CTRL's 6-bit stall pattern for stallreq_for_ex SHALL remain the sole freeze mechanism.

Verification
REQ-027 Unsigned 100/7 at t -> stallreq_for_ex high t..t+32, ready_o at t+33, result_o={32'd2,32'd14}.
REQ-028 Signed -7/2 -> result_o={32'hFFFF_FFFF,32'hFFFF_FFFD}. Signed 0x80000000/-1 -> {0,32'h8000_0000}.
REQ-029 Divisor 0, dividend 5, macro defined -> ready_o at t+2, result_o={32'd5,32'hFFFF_FFFF}. Macro undefined -> ready_o at t+33.
REQ-030 annul_i pulsed at t+10 -> state FREE at t+11, ready_o never asserted, stallreq_for_ex 0 from t+10.
REQ-031 rst asserted between edges at t+15 -> result_o, ready_o and stallreq_for_ex (with start_i low) go 0 immediately. A new 100/7 start after release completes in 33 cycles.
REQ-032 Back-to-back 9/3 then 10/4 with start_i held high -> ready_o pulses at t+33 and t+67, results {0,3} then {2,2}.
